// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant
//
// Purpose:
//   Shares one resource among N requesters.
//   The next owner is the first requester found scanning from ptr+1 upward, wrapping mod N.
//   ptr always holds the most recent owner.
//   The grant is registered and held for as long as the owner keeps requesting.
//   When the owner releases, and someone else is waiting, the grant moves on the next edge without an idle cycle.
//
// Optional feature (macro RR_HOLD_TIMEOUT_EN):
//   A contended owner is pre-empted after MAX_HOLD consecutive grant cycles.
//   Without the macro, no hold counter exists.
//
// Parameters:
//   N         number of requesters
//   W         index width, must equal clog2(N)
//   MAX_HOLD  max consecutive contended grant cycles (timeout build only)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        request vector, bit i = requester i
//   gnt        one-hot grant, registered
//   gnt_id     binary index of the granted requester, 0 when idle
//   gnt_valid  high while a grant is active

module rr_arbiter #(
  parameter int N        = 8,
  parameter int W        = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state;
  logic [W-1:0] ptr;
  logic [W-1:0] win_id;
  logic [N-1:0] win_onehot;
  logic         win_found;

  if (W != $clog2(N)) begin : g_bad_w
    $error("rr_arbiter: W must equal clog2(N)");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("rr_arbiter: MAX_HOLD must be at least 1");
  end

`ifdef RR_HOLD_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HW-1:0] hold_cnt;
`endif

  // Rotating search.
  // While a grant is held, ptr equals the owner, so the owner itself is found last.
  // Consequently, win_id != gnt_id means some other requester is waiting.
  always_comb begin
    int           pos;
    logic [W-1:0] idx;
    win_id     = '0;
    win_onehot = '0;
    win_found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(ptr) + k) % N;
      idx = pos[W-1:0];
      if (!win_found && req[idx]) begin
        win_found       = 1'b1;
        win_id          = idx;
        win_onehot[idx] = 1'b1;
      end
    end
  end

  assign gnt_valid = (state == GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= W'(N - 1);
`ifdef RR_HOLD_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            gnt      <= win_onehot;
            gnt_id   <= win_id;
            ptr      <= win_id;
`ifdef RR_HOLD_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (!req[gnt_id]) begin
            if (win_found) begin
              // Owner released with others waiting: hand over directly.
              gnt      <= win_onehot;
              gnt_id   <= win_id;
              ptr      <= win_id;
`ifdef RR_HOLD_TIMEOUT_EN
              hold_cnt <= '0;
`endif
            end else begin
              // ptr keeps the old owner, so it is searched last next time.
              state  <= IDLE;
              gnt    <= '0;
              gnt_id <= '0;
            end
          end
`ifdef RR_HOLD_TIMEOUT_EN
          else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
            hold_cnt <= '0;
            if (win_id != gnt_id) begin
              gnt    <= win_onehot;
              gnt_id <= win_id;
              ptr    <= win_id;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state  <= IDLE;
          gnt    <= '0;
          gnt_id <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - scoreboard bench for rr_arbiter

module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       v;
    logic [2:0] id;
  } exp_t;

  exp_t exp_q[$];

  rr_arbiter #(.N(8), .W(3), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] encode(input logic [7:0] v);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = 32'(i);
    return r;
  endfunction

  // Output consistency, independent of the expected owner.
  task automatic check_inv();
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("id_enc", 32'(gnt_id), encode(gnt));
    chk("valid_or", 32'(gnt_valid), 32'(|gnt));
  endtask

  // Pop the oldest expectation and compare against the DUT outputs.
  task automatic compare_head(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(e.v));
    chk({tag, ".id"}, 32'(gnt_id), e.v ? 32'(e.id) : 32'd0);
    chk({tag, ".gnt"}, 32'(gnt), e.v ? 32'(8'd1 << e.id) : 32'd0);
    check_inv();
  endtask

  // Drive req for one cycle.
  // The expectation is queued at drive time and checked after the edge.
  task automatic step(input string tag, input logic [7:0] r, input logic v, input logic [2:0] id);
    exp_q.push_back('{v: v, id: id});
    req = r;
    @(posedge clk);
    #1;
    compare_head(tag);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    @(posedge clk);
    #1;
    exp_q.push_back('{v: 1'b0, id: 3'd0});
    compare_head("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) step("idle", 8'h00, 1'b0, 3'd0);

    step("first_low", 8'b0001_0100, 1'b1, 3'd2);
    step("handover", 8'b0001_0000, 1'b1, 3'd4);
    step("release", 8'h00, 1'b0, 3'd0);

    rst_pulse();
    step("fair_start", 8'hFF, 1'b1, 3'd0);
    for (int i = 0; i < 8; i++)
      step("fair", 8'hFF ^ (8'd1 << i), 1'b1, 3'((i + 1) % 8));
    step("fair_end", 8'h00, 1'b0, 3'd0);

    step("own5", 8'b0010_0000, 1'b1, 3'd5);
    step("own5_hold", 8'b0010_0000, 1'b1, 3'd5);
    step("own5_drop", 8'h00, 1'b0, 3'd0);
    step("wrap", 8'b0010_0001, 1'b1, 3'd0);
    step("wrap_end", 8'h00, 1'b0, 3'd0);

    rst_pulse();
    for (int i = 0; i < 9; i++) begin
`ifdef RR_HOLD_TIMEOUT_EN
      step("hold", 8'b0000_1001, 1'b1, ((i / 4) % 2 == 1) ? 3'd3 : 3'd0);
`else
      step("hold", 8'b0000_1001, 1'b1, 3'd0);
`endif
    end
    step("hold_end", 8'h00, 1'b0, 3'd0);

    step("own6", 8'b0100_0000, 1'b1, 3'd6);
    rst = 1'b1;
    #1;
    exp_q.push_back('{v: 1'b0, id: 3'd0});
    compare_head("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst", 8'b1100_0000, 1'b1, 3'd6);
    step("post_rst_hold", 8'b1100_0000, 1'b1, 3'd6);
    step("post_rst_next", 8'b1000_0000, 1'b1, 3'd7);
    step("final", 8'h00, 1'b0, 3'd0);

    if (exp_q.size() != 0) chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
